// File: rtl/hamming_pkg.sv
// Shared SECDED definitions for the hamming encoder, DEC_CHK and the bench:
// code geometry per work mode, H matrix rows and the padded codeword type.
package hamming_pkg;

   localparam int unsigned CW_WIDTH   = 32;
   localparam int unsigned INFO_WIDTH = 26;
   localparam int unsigned PAR_ROWS   = 5;

   localparam int unsigned K_8_4   = 4;
   localparam int unsigned P_8_4   = 4;
   localparam int unsigned N_8_4   = 8;
   localparam int unsigned K_16_11 = 11;
   localparam int unsigned P_16_11 = 5;
   localparam int unsigned N_16_11 = 16;
   localparam int unsigned K_32_26 = 26;
   localparam int unsigned P_32_26 = 6;
   localparam int unsigned N_32_26 = 32;

   typedef enum logic [1:0] {
      MOD_8_4   = 2'd0,
      MOD_16_11 = 2'd1,
      MOD_32_26 = 2'd2,
      MOD_RSVD  = 2'd3
   } work_mode_t;

   typedef logic [CW_WIDTH-1:0] codeword_t;

   // H rows without the all-ones overall-parity row; index 0 = row 0
   localparam logic [2:0][7:0]  H_ROWS_8_4   = {8'hE4, 8'hD2, 8'hB1};
   localparam logic [3:0][15:0] H_ROWS_16_11 = {16'hFE08, 16'hF1C4, 16'hCDA2, 16'hAB61};
   localparam logic [4:0][31:0] H_ROWS_32_26 = {32'hFFFE0010, 32'hFF01FC08, 32'hF0F1E384,
                                                32'hCCCD9B42, 32'hAAAB56C1};

   function automatic logic [INFO_WIDTH-1:0] info_mask(input work_mode_t mode);
      logic [INFO_WIDTH-1:0] mask;
      case (mode)
         MOD_8_4:   mask = 26'h000_000F;
         MOD_16_11: mask = 26'h000_07FF;
         MOD_32_26: mask = 26'h3FF_FFFF;
         default:   mask = '0;
      endcase
      return mask;
   endfunction

   // Info-bit columns of H row 'row', i.e. the row shifted down past the parity bits
   function automatic logic [INFO_WIDTH-1:0] row_info_sel(input work_mode_t mode,
                                                          input logic [2:0] row);
      logic [INFO_WIDTH-1:0] sel;
      sel = '0;
      case (mode)
         MOD_8_4:   if (row < 3'd3) sel = {22'b0, H_ROWS_8_4[row[1:0]][7:4]};
         MOD_16_11: if (row < 3'd4) sel = {15'b0, H_ROWS_16_11[row[1:0]][15:5]};
         MOD_32_26: if (row < 3'd5) sel = H_ROWS_32_26[row][31:6];
         default:   sel = '0;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/hamming_enc_parity_calc.sv
// Combinational H-row parities over a masked info word; rows beyond the
// selected mode's P-1 come out as zero.
module hamming_parity_calc
   import hamming_pkg::*;
(
   input  logic [INFO_WIDTH-1:0] info,
   input  work_mode_t            mode,
   output logic [PAR_ROWS-1:0]   row_par
);

   always_comb begin
      row_par = '0;
      for (int k = 0; k < PAR_ROWS; k++) begin
         row_par[k] = ^(info & row_info_sel(mode, 3'(k)));
      end
   end

endmodule

// File: rtl/hamming_enc.sv
// SECDED encoder: two-stage elastic pipeline (S1 = masked info + row parities,
// S2 = assembled codeword output register) with valid/ready on both sides.
module hamming_enc
   import hamming_pkg::*;
#(
   parameter int unsigned MAX_CODEWORD_WIDTH = 32,
   parameter int unsigned MAX_INFO_WIDTH     = 26
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [MAX_INFO_WIDTH-1:0]     data_in,
   input  logic [1:0]                    work_mod,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
   output logic                          mode_err
);

   localparam int unsigned MAX_PARITY_WIDTH = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;

   work_mode_t                  in_mode;
   logic [MAX_INFO_WIDTH-1:0]   in_info;
   logic [MAX_PARITY_WIDTH-2:0] in_par;

   logic                        s1_valid_q, s1_valid_d;
   logic [MAX_INFO_WIDTH-1:0]   s1_info_q;
   work_mode_t                  s1_mode_q;
   logic [MAX_PARITY_WIDTH-2:0] s1_par_q;

   logic                        out_valid_q;
   codeword_t                   data_out_q;
   logic                        mode_err_q;

   logic                        s2_load;
   logic                        in_fire;
   logic                        overall;
   codeword_t                   cw;

   assign in_mode = work_mode_t'(work_mod);
   assign in_info = data_in & info_mask(in_mode);

   hamming_parity_calc u_parity_calc (
      .info    (in_info),
      .mode    (in_mode),
      .row_par (in_par)
   );

   assign s2_load  = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_load;
   assign in_fire  = in_valid && in_ready;

   always_comb begin
      s1_valid_d = s1_valid_q;
      if (in_fire) begin
         s1_valid_d = 1'b1;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s1_info_q  <= '0;
         s1_mode_q  <= MOD_8_4;
         s1_par_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (in_fire) begin
            s1_info_q <= in_info;
            s1_mode_q <= in_mode;
            s1_par_q  <= in_par;
         end
      end
   end

   // Info is pre-masked and unused row parities are zero, so one XOR serves every mode
   assign overall = ^{s1_info_q, s1_par_q};

   always_comb begin
      cw = '0;
      case (s1_mode_q)
         MOD_8_4:   cw = {24'b0, s1_info_q[3:0], overall, s1_par_q[2:0]};
         MOD_16_11: cw = {16'b0, s1_info_q[10:0], overall, s1_par_q[3:0]};
         MOD_32_26: cw = {s1_info_q, overall, s1_par_q};
         default:   cw = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         data_out_q  <= '0;
         mode_err_q  <= 1'b0;
      end else if (s2_load) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            data_out_q <= cw;
            mode_err_q <= (s1_mode_q == MOD_RSVD);
         end
      end
   end

   assign out_valid = out_valid_q;
   assign data_out  = data_out_q;
   assign mode_err  = mode_err_q;

endmodule

// File: tb/tb_hamming_enc.sv
// Scoreboard bench for hamming_enc: stimulus pushes expected codewords, a
// negedge monitor pops and compares them and re-checks the syndrome.
module tb_hamming_enc;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [25:0] data_in;
   logic [1:0]  work_mod;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] data_out;
   logic        mode_err;

   typedef struct {
      logic [31:0] cw;
      logic        merr;
      logic [1:0]  mode;
      int          cyc;
      bit          lat;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          checks = 0;
   int          errors = 0;
   int          cycle = 0;
   int          out_count = 0;
   int          acc_count = 0;
   bit          lat_check = 1'b1;
   bit          done;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic        prev_merr;
   int          start_cyc;
   int          start_out;

   hamming_enc dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .work_mod  (work_mod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .mode_err  (mode_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   function automatic int k_of(input logic [1:0] m);
      return (m == 2'd0) ? 4 : (m == 2'd1) ? 11 : 26;
   endfunction

   function automatic int p_of(input logic [1:0] m);
      return (m == 2'd0) ? 4 : (m == 2'd1) ? 5 : 6;
   endfunction

   function automatic logic [31:0] h_row(input logic [1:0] m, input int r);
      logic [31:0] row;
      row = 32'h0;
      case (m)
         2'd0: case (r)
            0: row = 32'hB1; 1: row = 32'hD2; 2: row = 32'hE4; default: row = 32'h0;
         endcase
         2'd1: case (r)
            0: row = 32'hAB61; 1: row = 32'hCDA2; 2: row = 32'hF1C4; 3: row = 32'hFE08;
            default: row = 32'h0;
         endcase
         2'd2: case (r)
            0: row = 32'hAAAB56C1; 1: row = 32'hCCCD9B42; 2: row = 32'hF0F1E384;
            3: row = 32'hFF01FC08; 4: row = 32'hFFFE0010; default: row = 32'h0;
         endcase
         default: row = 32'h0;
      endcase
      return row;
   endfunction

   // Place info above the parity field, then pick each parity bit so its row has even weight
   function automatic logic [31:0] model(input logic [1:0] m, input logic [25:0] d);
      logic [31:0] cw;
      int kk, pp;
      cw = 32'h0;
      if (m == 2'd3) return cw;
      kk = k_of(m);
      pp = p_of(m);
      for (int i = 0; i < kk; i++) cw[pp + i] = d[i];
      for (int r = 0; r < pp - 1; r++)
         if ($countones(cw & h_row(m, r)) % 2 == 1) cw[r] = 1'b1;
      if ($countones(cw) % 2 == 1) cw[pp - 1] = 1'b1;
      return cw;
   endfunction

   // Number of violated parity checks (incl. all-ones row and bits above the code length)
   function automatic int synd_bad(input logic [1:0] m, input logic [31:0] cw);
      int bad, n;
      bad = 0;
      n = k_of(m) + p_of(m);
      for (int r = 0; r < p_of(m) - 1; r++)
         if ($countones(cw & h_row(m, r)) % 2 == 1) bad++;
      if ($countones(cw) % 2 == 1) bad++;
      if (n < 32 && (cw >> n) != 32'h0) bad++;
      return bad;
   endfunction

   // Entered at posedge+1; returns at posedge+1 right after the transfer edge
   task automatic send(input logic [1:0] m, input logic [25:0] d,
                       input logic [31:0] exp_cw, input logic exp_merr);
      bit ok;
      int n;
      in_valid = 1'b1;
      data_in  = d;
      work_mod = m;
      n = 0;
      forever begin
         @(negedge clk);
         ok = in_ready;
         if (ok) begin
            sb.push_back('{cw: exp_cw, merr: exp_merr, mode: m, cyc: cycle, lat: lat_check});
            acc_count++;
         end
         @(posedge clk);
         #1;
         if (ok) break;
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: actual in_ready=0 for %0d cycles required acceptance", n);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic send_model(input logic [1:0] m, input logic [25:0] d);
      send(m, d, model(m, d), m == 2'd3);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      @(posedge clk);
      #1;
      check("drain_empty", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", data_out, prev_data);
            check("stall_merr", mode_err, prev_merr);
         end
         if (out_valid && out_ready) begin
            out_count++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: actual %h required no output", data_out);
            end else begin
               e = sb.pop_front();
               check("data_out", data_out, e.cw);
               check("mode_err", mode_err, e.merr);
               if (e.lat) check("latency", cycle - e.cyc, 2);
               if (!e.merr) check("syndrome", synd_bad(e.mode, data_out), 0);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = data_out;
         prev_merr  = mode_err;
      end
   end

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      data_in   = '0;
      work_mod  = 2'd0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_data_out", data_out, 0);
      check("rst_mode_err", mode_err, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("idle_out_valid", out_valid, 0);
      @(posedge clk);
      #1;

      // Directed vectors, streaming back-to-back with out_ready held high
      send(2'd0, 26'hB, 32'h0000_00B1, 1'b0);
      send(2'd0, 26'hF, 32'h0000_00FF, 1'b0);
      send(2'd0, 26'h0, 32'h0000_0000, 1'b0);
      send(2'd1, 26'h001, 32'h0000_0033, 1'b0);
      send(2'd2, 26'h1, 32'h0000_0063, 1'b0);
      send(2'd0, 26'h3FFFFF0, 32'h0000_0000, 1'b0);
      drain();

      // Random full-throughput stream
      start_cyc = cycle;
      start_out = out_count;
      repeat (100) send_model(2'($urandom_range(0, 2)), 26'($urandom));
      drain();
      check("stream_count", out_count - start_out, 100);
      check("stream_rate", (cycle - start_cyc) <= 106, 1);

      // Random stream with random backpressure
      lat_check = 1'b0;
      done = 1'b0;
      fork
         begin
            repeat (60) send_model(2'($urandom_range(0, 3)), 26'($urandom));
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Directed backpressure: S2 and S1 fill, third word waits for release
      acc_count = 0;
      out_ready = 1'b0;
      fork
         begin
            send_model(2'd0, 26'h5);
            send_model(2'd1, 26'h2A5);
            send_model(2'd2, 26'h2345678);
         end
         begin
            repeat (5) @(negedge clk);
            check("bp_accepted", acc_count, 2);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check("bp_total", acc_count, 3);

      // Reserved mode then a normal word
      lat_check = 1'b1;
      send(2'd3, 26'h155, 32'h0, 1'b1);
      send(2'd0, 26'hB, 32'h0000_00B1, 1'b0);
      drain();

      // Reset with two words in flight
      send_model(2'd2, 26'($urandom));
      send_model(2'd1, 26'($urandom));
      rst = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_data_out", data_out, 0);
      check("midrst_mode_err", mode_err, 0);
      sb.delete();
      start_out = out_count;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("postrst_in_ready", in_ready, 1);
      repeat (4) @(negedge clk);
      check("postrst_no_stale", out_count - start_out, 0);
      check("postrst_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      send_model(2'd1, 26'h3A5);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
